// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - shared states, default constants and stage-size helper for the FFT stage sequencer
package fft_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    localparam int DEF_ADDR_WIDTH      = 12;
    localparam int DEF_CYCLES_PER_BFLY = 10;
    localparam int DEF_DRAIN_CYCLES    = 8;
    localparam int DEF_LOAD_CYCLES     = 2;
    localparam int DEF_MIN_LOG2        = 2;
    localparam int DEF_MAX_LOG2        = 11;

    // A radix-2 stage of N points holds N/2 butterflies.
    function automatic int unsigned bflies_per_stage(input logic [3:0] log2_n);
        return (log2_n == 4'd0) ? 32'd1 : (32'd1 << (log2_n - 4'd1));
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - host and controller signal bundle; FFT_SEQ_PERF_CNT_EN adds cycle_count/stall_err
interface fft_stage_sequencer_if
    import fft_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  start;
    logic [3:0]            log2_n;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;
    logic [3:0]            stage_number;
    logic [3:0]            stage_level;
    logic [ADDR_WIDTH-1:0] max_point_fft;
    logic                  ena_fft_core;
    logic                  ena_fft_wait;
    logic                  ena_mul_fp_clk;
    logic                  stage_done;
`ifdef FFT_SEQ_PERF_CNT_EN
    logic [23:0]           cycle_count;
    logic                  stall_err;

    modport master (
        output start, log2_n, abort,
        input  busy, done, cfg_err, stage_number, stage_level, max_point_fft,
               ena_fft_core, ena_fft_wait, ena_mul_fp_clk, stage_done,
               cycle_count, stall_err
    );

    modport slave (
        input  start, log2_n, abort,
        output busy, done, cfg_err, stage_number, stage_level, max_point_fft,
               ena_fft_core, ena_fft_wait, ena_mul_fp_clk, stage_done,
               cycle_count, stall_err
    );
`else
    modport master (
        output start, log2_n, abort,
        input  busy, done, cfg_err, stage_number, stage_level, max_point_fft,
               ena_fft_core, ena_fft_wait, ena_mul_fp_clk, stage_done
    );

    modport slave (
        input  start, log2_n, abort,
        output busy, done, cfg_err, stage_number, stage_level, max_point_fft,
               ena_fft_core, ena_fft_wait, ena_mul_fp_clk, stage_done
    );
`endif

endinterface

// File: rtl/fft_seq_slot_timer.sv
// rtl/fft_seq_slot_timer.sv - butterfly slot / butterfly counter pair that times one RUN phase
module fft_seq_slot_timer
    import fft_seq_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int CYCLES_PER_BFLY = DEF_CYCLES_PER_BFLY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic [3:0] log2_n,
    output logic       slot_last,
    output logic       run_last
);

    localparam int SLOT_W = (CYCLES_PER_BFLY > 1) ? $clog2(CYCLES_PER_BFLY) : 1;
    localparam int BFLY_W = ADDR_WIDTH - 1;
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(CYCLES_PER_BFLY - 1);

    logic [SLOT_W-1:0] slot;
    logic [BFLY_W-1:0] bfly;
    logic [BFLY_W-1:0] bfly_max;

    // End of RUN is matched field by field so the full-length product is never formed.
    assign bfly_max  = BFLY_W'(bflies_per_stage(log2_n) - 32'd1);
    assign slot_last = (slot == SLOT_MAX);
    assign run_last  = slot_last && (bfly == bfly_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
            bfly <= '0;
        end else if (clear) begin
            slot <= '0;
            bfly <= '0;
        end else if (enable) begin
            if (slot_last) begin
                slot <= '0;
                bfly <= bfly + 1'b1;
            end else begin
                slot <= slot + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - stage sequencer for one in-place radix-2 FFT run; FFT_SEQ_PERF_CNT_EN adds cycle/abort telemetry
module fft_stage_sequencer
    import fft_seq_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int CYCLES_PER_BFLY = DEF_CYCLES_PER_BFLY,
    parameter int DRAIN_CYCLES    = DEF_DRAIN_CYCLES,
    parameter int LOAD_CYCLES     = DEF_LOAD_CYCLES,
    parameter int MIN_LOG2        = DEF_MIN_LOG2,
    parameter int MAX_LOG2        = DEF_MAX_LOG2
) (
    input logic                  clk,
    input logic                  rst_n,
    fft_stage_sequencer_if.slave bus
);

    localparam int PHASE_MAX = (DRAIN_CYCLES > LOAD_CYCLES) ? DRAIN_CYCLES : LOAD_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam logic [PHASE_W-1:0] LOAD_LAST  = PHASE_W'(LOAD_CYCLES - 1);
    localparam logic [PHASE_W-1:0] DRAIN_LAST = PHASE_W'(DRAIN_CYCLES - 1);
    localparam logic [3:0] MIN_L = 4'(MIN_LOG2);
    localparam logic [3:0] MAX_L = 4'(MAX_LOG2);

    seq_state_e            state_q, state_d;
    logic [3:0]            stage_number_q;
    logic [3:0]            stage_level_q;
    logic [ADDR_WIDTH-1:0] max_point_q;
    logic [PHASE_W-1:0]    phase_q;
    logic                  cfg_err_q;
    logic                  size_ok;
    logic                  start_ok;
    logic                  last_stage;
    logic                  slot_last;
    logic                  run_last;
    logic                  busy_c, done_c, core_c, wait_c, mul_c, sdone_c;

    assign size_ok    = (bus.log2_n >= MIN_L) && (bus.log2_n <= MAX_L);
    assign start_ok   = (state_q == IDLE) && bus.start && !bus.abort && size_ok;
    assign last_stage = (stage_level_q == stage_number_q - 4'd1);

    fft_seq_slot_timer #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .CYCLES_PER_BFLY (CYCLES_PER_BFLY)
    ) u_slot_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (state_q == RUN),
        .clear     (state_d != RUN),
        .log2_n    (stage_number_q),
        .slot_last (slot_last),
        .run_last  (run_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_c  = (state_q != IDLE);
        done_c  = (state_q == DONE);
        core_c  = (state_q == RUN);
        wait_c  = (state_q == DRAIN);
        mul_c   = (state_q == RUN) && slot_last;
        sdone_c = (state_q == DRAIN) && (phase_q == DRAIN_LAST);
        case (state_q)
            IDLE:    if (start_ok) state_d = LOAD;
            LOAD:    if (phase_q == LOAD_LAST) state_d = RUN;
            RUN:     if (run_last) state_d = DRAIN;
            DRAIN:   if (phase_q == DRAIN_LAST) state_d = last_stage ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort outranks every transition, including the final DRAIN->DONE.
        if (bus.abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_number_q <= '0;
            stage_level_q  <= '0;
            max_point_q    <= '0;
            phase_q        <= '0;
            cfg_err_q      <= 1'b0;
        end else begin
            cfg_err_q <= (state_q == IDLE) && bus.start && !bus.abort && !size_ok;
            if (start_ok) begin
                stage_number_q <= bus.log2_n;
                stage_level_q  <= '0;
                max_point_q    <= ADDR_WIDTH'((32'd1 << bus.log2_n) - 32'd1);
            end else if (state_q == DRAIN && state_d == LOAD) begin
                stage_level_q <= stage_level_q + 4'd1;
            end
            if (state_d != state_q)
                phase_q <= '0;
            else if (state_q == LOAD || state_q == DRAIN)
                phase_q <= phase_q + 1'b1;
        end
    end

`ifdef FFT_SEQ_PERF_CNT_EN
    logic [23:0] cycle_count_q;
    logic        stall_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_q <= '0;
            stall_err_q   <= 1'b0;
        end else begin
            stall_err_q <= bus.abort && (state_q != IDLE);
            if (start_ok)
                cycle_count_q <= '0;
            else if (busy_c && cycle_count_q != '1)
                cycle_count_q <= cycle_count_q + 1'b1;
        end
    end

    assign bus.cycle_count = cycle_count_q;
    assign bus.stall_err   = stall_err_q;
`else
`endif

    assign bus.busy           = busy_c;
    assign bus.done           = done_c;
    assign bus.cfg_err        = cfg_err_q;
    assign bus.stage_number   = stage_number_q;
    assign bus.stage_level    = stage_level_q;
    assign bus.max_point_fft  = max_point_q;
    assign bus.ena_fft_core   = core_c;
    assign bus.ena_fft_wait   = wait_c;
    assign bus.ena_mul_fp_clk = mul_c;
    assign bus.stage_done     = sdone_c;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - directed self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.ADDR_WIDTH(12)) bus ();

    fft_stage_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_core = 0, n_wait = 0, n_mul = 0, n_sdone = 0, n_done = 0, n_both = 0;

    always @(negedge clk) begin
        if (bus.ena_fft_core)   n_core++;
        if (bus.ena_fft_wait)   n_wait++;
        if (bus.ena_mul_fp_clk) n_mul++;
        if (bus.stage_done)     n_sdone++;
        if (bus.done)           n_done++;
        if (bus.ena_fft_core && bus.ena_fft_wait) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start with size n, optionally pulse a second start at negedge inj_k,
    // and return the negedge index at which done is seen (0 if never).
    task automatic run_seq(input logic [3:0] n, input int inj_k, input int bound, output int lat);
        lat = 0;
        bus.log2_n = n;
        bus.start  = 1'b1;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == inj_k) begin
                bus.start  = 1'b1;
                bus.log2_n = 4'd2;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    int lat;
    int c0, w0, m0, s0, d0;
    int runlen, mulcnt, first_mul;

    initial begin
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.log2_n = 4'd0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_core", 32'(bus.ena_fft_core), 0);
        check("rst_stage_number", 32'(bus.stage_number), 0);
        check("rst_max_point", 32'(bus.max_point_fft), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal log2_n = 3
        c0 = n_core; w0 = n_wait; m0 = n_mul; s0 = n_sdone; d0 = n_done;
        run_seq(4'd3, 0, 300, lat);
        check("nom_latency", lat, 151);
        check("nom_busy_in_done", 32'(bus.busy), 1);
        check("nom_stage_level", 32'(bus.stage_level), 2);
        check("nom_max_point", 32'(bus.max_point_fft), 7);
        check("nom_stage_number", 32'(bus.stage_number), 3);
        @(negedge clk);
        check("nom_idle_busy", 32'(bus.busy), 0);
        check("nom_done_cleared", 32'(bus.done), 0);
        check("nom_core_cycles", n_core - c0, 120);
        check("nom_wait_cycles", n_wait - w0, 24);
        check("nom_mul_pulses", n_mul - m0, 12);
        check("nom_stage_done", n_sdone - s0, 3);
        check("nom_done_pulses", n_done - d0, 1);
`ifdef FFT_SEQ_PERF_CNT_EN
        check("nom_cycle_count", 32'(bus.cycle_count), 151);
`endif

        // Out-of-range sizes
        bus.log2_n = 4'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("bad1_cfg_err", 32'(bus.cfg_err), 1);
        check("bad1_busy", 32'(bus.busy), 0);
        check("bad1_stage_number", 32'(bus.stage_number), 3);
        @(negedge clk);
        check("bad1_cfg_err_pulse", 32'(bus.cfg_err), 0);
        bus.log2_n = 4'd12; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("bad12_cfg_err", 32'(bus.cfg_err), 1);
        check("bad12_busy", 32'(bus.busy), 0);
        check("bad12_max_point", 32'(bus.max_point_fft), 7);

        // Abort and start together in IDLE: abort wins
        bus.log2_n = 4'd3; bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check("abort_start_busy", 32'(bus.busy), 0);
        check("abort_start_cfg_err", 32'(bus.cfg_err), 0);

        // Abort in stage 1 RUN cycle 25 of a log2_n = 4 run
        d0 = n_done; s0 = n_sdone;
        bus.log2_n = 4'd4; bus.start = 1'b1;
        for (int k = 1; k <= 118; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("abort_pre_core", 32'(bus.ena_fft_core), 1);
        check("abort_pre_level", 32'(bus.stage_level), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_core", 32'(bus.ena_fft_core), 0);
        check("abort_wait", 32'(bus.ena_fft_wait), 0);
        check("abort_mul", 32'(bus.ena_mul_fp_clk), 0);
`ifdef FFT_SEQ_PERF_CNT_EN
        check("abort_stall_err", 32'(bus.stall_err), 1);
`endif
        repeat (3) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        check("abort_stage_done", n_sdone - s0, 1);
        run_seq(4'd2, 0, 200, lat);
        check("post_abort_latency", lat, 61);
        check("post_abort_max_point", 32'(bus.max_point_fft), 3);
        @(negedge clk);

        // Start pulsed during stage 0 DRAIN of a log2_n = 5 run is ignored
        d0 = n_done; s0 = n_sdone;
        run_seq(4'd5, 165, 1200, lat);
        check("ign_latency", lat, 851);
        check("ign_stage_number", 32'(bus.stage_number), 5);
        check("ign_stage_level", 32'(bus.stage_level), 4);
        @(negedge clk);
        check("ign_done_pulses", n_done - d0, 1);
        check("ign_stage_done", n_sdone - s0, 5);
        check("ign_idle", 32'(bus.busy), 0);

        // Asynchronous reset in RUN
        bus.log2_n = 4'd3; bus.start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("arst_pre_core", 32'(bus.ena_fft_core), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_core", 32'(bus.ena_fft_core), 0);
        check("arst_stage_number", 32'(bus.stage_number), 0);
        check("arst_max_point", 32'(bus.max_point_fft), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_seq(4'd2, 0, 200, lat);
        check("arst_restart_latency", lat, 61);
        @(negedge clk);

        // Largest size: first stage RUN length and slot position of the multiplier pulse
        runlen = 0; mulcnt = 0; first_mul = -1;
        bus.log2_n = 4'd11; bus.start = 1'b1;
        for (int k = 1; k <= 10400; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.ena_fft_core) runlen++;
            if (bus.ena_mul_fp_clk) begin
                mulcnt++;
                if (first_mul < 0) first_mul = runlen - 1;
            end
            if (bus.ena_fft_wait) break;
        end
        check("max_run_length", runlen, 10240);
        check("max_mul_pulses", mulcnt, 1024);
        check("max_first_mul_slot", first_mul, 9);
        check("max_in_drain", 32'(bus.ena_fft_wait), 1);
        check("max_point_2047", 32'(bus.max_point_fft), 2047);
        check("max_stage_number", 32'(bus.stage_number), 11);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("max_abort_busy", 32'(bus.busy), 0);

        check("core_wait_exclusive", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
